// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_pkg: shared types and constants for the LED pattern generator.
//   mode_e  : externally selected pattern mode (2-bit encoding on mode_i)
//   state_e : internal pattern FSM states
//   PAT_*   : pattern loaded when a mode is entered
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'b00,
    MODE_SCAN  = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_COUNT,
    S_SCAN_L,
    S_SCAN_R,
    S_BLINK,
    S_HOLD
  } state_e;

  localparam logic [7:0] PAT_COUNT_INIT = 8'h00;
  localparam logic [7:0] PAT_SCAN_INIT  = 8'h01;
  localparam logic [7:0] PAT_BLINK_INIT = 8'hAA;

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_if: control/status bundle of the LED pattern generator.
//   enable_i : prescaler run enable
//   mode_i   : pattern mode select (mode_e)
//   duty_i   : PWM brightness, present only when LED_PWM_EN is defined
//   tick_o   : one-cycle pulse per pattern step
//   leds_o   : registered LED drive vector
// Modports: master = controller side, slave = generator side.
interface led_pattern_if
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W = 8,
  parameter int unsigned PWM_W = 4
);
  logic             enable_i;
  mode_e            mode_i;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty_i;
`endif
  logic             tick_o;
  logic [LED_W-1:0] leds_o;

`ifdef LED_PWM_EN
  modport master (output enable_i, mode_i, duty_i, input tick_o, leds_o);
  modport slave  (input enable_i, mode_i, duty_i, output tick_o, leds_o);
`else
  modport master (output enable_i, mode_i, input tick_o, leds_o);
  modport slave  (input enable_i, mode_i, output tick_o, leds_o);
`endif
endinterface

// File: rtl/led_pattern_gen_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle step tick.
//   clk, rst_n : clock, async active-low reset
//   enable_i   : 1 = count runs, 0 = count frozen and tick suppressed
//   tick_o     : high while cnt sits at its last value and enable_i is high
// tick_o is decoded from the cnt register (plus enable_i), so it is clean
// for the whole cycle; freezing keeps cnt so a resume finishes the period.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 12_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);
  localparam int unsigned    CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (enable_i) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick_o = enable_i && (cnt == LAST);
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: 8-bit LED pattern generator (COUNT / SCAN / BLINK / HOLD).
//   clk, rst_n : single clock, async active-low reset
//   bus        : led_pattern_if.slave (enable_i, mode_i, [duty_i], tick_o, leds_o)
// Build option LED_PWM_EN: adds duty_i and a free-running PWM that gates
// leds_o; without it leds_o is simply pat_q delayed one clock.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned PRESCALE = 12_000_000,
  parameter int unsigned PWM_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  led_pattern_if.slave bus
);
  localparam logic [LED_W-1:0] ONE = LED_W'(1);
  localparam logic [LED_W-1:0] MSB = ONE << (LED_W - 1);

  logic             tick;
  mode_e            mode_q;
  state_e           state;
  logic [LED_W-1:0] pat_q, nxt_l, nxt_r;
  logic             onehot;
  logic             gate;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (bus.enable_i),
    .tick_o   (tick)
  );

  assign bus.tick_o = tick;
  assign nxt_l  = pat_q << 1;
  assign nxt_r  = pat_q >> 1;
  assign onehot = (pat_q != '0) && ((pat_q & (pat_q - ONE)) == '0);

  // Pattern FSM: everything advances only on a tick. A mode change takes
  // priority over stepping and (re)loads the mode's initial pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_COUNT;
      state  <= S_COUNT;
      pat_q  <= LED_W'(PAT_COUNT_INIT);
    end else if (tick) begin
      if (bus.mode_i != mode_q) begin
        mode_q <= bus.mode_i;
        unique case (bus.mode_i)
          MODE_COUNT: begin state <= S_COUNT;  pat_q <= LED_W'(PAT_COUNT_INIT); end
          MODE_SCAN:  begin state <= S_SCAN_L; pat_q <= LED_W'(PAT_SCAN_INIT);  end
          MODE_BLINK: begin state <= S_BLINK;  pat_q <= LED_W'(PAT_BLINK_INIT); end
          default:          state <= S_HOLD;  // HOLD keeps whatever is shown
        endcase
      end else begin
        unique case (state)
          S_COUNT: pat_q <= pat_q + ONE;
          // Both SCAN states recover from a corrupted (non-one-hot) pattern
          // by restarting the sweep from the right-hand end.
          S_SCAN_L: begin
            if (!onehot) begin
              pat_q <= LED_W'(PAT_SCAN_INIT);
            end else begin
              pat_q <= nxt_l;
              if (nxt_l == MSB) state <= S_SCAN_R;
            end
          end
          S_SCAN_R: begin
            if (!onehot) begin
              pat_q <= LED_W'(PAT_SCAN_INIT);
              state <= S_SCAN_L;
            end else begin
              pat_q <= nxt_r;
              if (nxt_r == ONE) state <= S_SCAN_L;
            end
          end
          S_BLINK: pat_q <= ~pat_q;
          default: ;                          // S_HOLD
        endcase
      end
    end
  end

`ifdef LED_PWM_EN
  // Free-running PWM, independent of enable_i. duty_i=0 is fully off and
  // the brightest setting still leaves one dark slot per period.
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign gate = (pwm_cnt < bus.duty_i);
`else
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.leds_o <= '0;
    else        bus.leds_o <= pat_q & {LED_W{gate}};
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int unsigned LED_W    = 8;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PWM_W    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  led_pattern_if #(.LED_W(LED_W), .PWM_W(PWM_W)) bus ();

  led_pattern_gen #(.LED_W(LED_W), .PRESCALE(PRESCALE), .PWM_W(PWM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected LED mask: all-on without PWM; with PWM an independent shadow of
  // the brightness gate registered alongside leds_o.
  logic tb_gate;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] tb_pwm;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin tb_pwm <= '0; tb_gate <= 1'b0; end
    else begin tb_gate <= (tb_pwm < bus.duty_i); tb_pwm <= tb_pwm + 1'b1; end
  end
`else
  assign tb_gate = 1'b1;
`endif

  function automatic logic [7:0] expl(input logic [7:0] p);
    return p & {8{tb_gate}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until tick_o is high; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick_o && n < 64);
    if (!bus.tick_o) chk("tick_timeout", 32'(bus.tick_o), 32'd1);
  endtask

  // One pattern step: tick, pattern update edge, output register edge.
  task automatic step(input string tag, input logic [7:0] exp);
    int n;
    wait_tick(n);
    @(negedge clk);
    @(negedge clk);
    chk(tag, 32'(bus.leds_o), 32'(expl(exp)));
  endtask

  logic [7:0] scan_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int n;
    logic [7:0] hold;
    rst_n        = 1'b0;
    bus.enable_i = 1'b0;
    bus.mode_i   = MODE_COUNT;
`ifdef LED_PWM_EN
    bus.duty_i   = 4'd15;
`endif
    #12;
    chk("reset_leds", 32'(bus.leds_o), 32'h0);
    chk("reset_tick", 32'(bus.tick_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) bus.enable_i = 1'b1;

    // COUNT: first tick after 3 edges from cnt=0, then every 4 clk
    wait_tick(n);
    chk("first_tick_lat", 32'(n), 32'd3);
    @(negedge clk);
    chk("tick_one_cycle", 32'(bus.tick_o), 32'd0);
    @(negedge clk);
    chk("count_01", 32'(bus.leds_o), 32'(expl(8'h01)));
    wait_tick(n);
    wait_tick(n);
    chk("tick_period", 32'(n), 32'd4);
    @(negedge clk);
    @(negedge clk);
    chk("count_03", 32'(bus.leds_o), 32'(expl(8'h03)));
    for (int k = 4; k <= 256; k++) step("count_seq", 8'(k));

    // Freeze mid-count for 20 clk (cnt held at 2), then resume
    @(negedge clk);
    bus.enable_i = 1'b0;
    hold = bus.leds_o;
    repeat (20) begin
      @(negedge clk);
      chk("frozen_tick", 32'(bus.tick_o), 32'd0);
      chk("frozen_leds", 32'(bus.leds_o), 32'(expl(hold)));
    end
    bus.enable_i = 1'b1;
    wait_tick(n);
    chk("resume_lat", 32'(n), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("resume_count", 32'(bus.leds_o), 32'(expl(8'h01)));

    // SCAN sweep, endpoints once each
    bus.mode_i = MODE_SCAN;
    step("scan_load", 8'h01);
    for (int k = 0; k < 15; k++) step("scan_seq", scan_exp[k]);

    // BLINK then HOLD
    bus.mode_i = MODE_BLINK;
    step("blink_0", 8'hAA);
    step("blink_1", 8'h55);
    step("blink_2", 8'hAA);
    bus.mode_i = MODE_HOLD;
    repeat (10) step("hold", 8'hAA);

    // Async reset mid-SCAN while tick_o is high, between clock edges
    bus.mode_i = MODE_SCAN;
    step("scan2_load", 8'h01);
    step("scan2_step", 8'h02);
    wait_tick(n);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(bus.leds_o), 32'h0);
    chk("async_rst_tick", 32'(bus.tick_o), 32'h0);
    bus.mode_i = MODE_COUNT;
    @(negedge clk) rst_n = 1'b1;
    chk("post_rst_leds", 32'(bus.leds_o), 32'h0);
    step("post_rst_1", 8'h01);
    step("post_rst_2", 8'h02);

`ifdef LED_PWM_EN
    // Brightness over one 16-clk PWM period with the pattern frozen at AA
    bus.mode_i = MODE_BLINK;
    step("pwm_blink", 8'hAA);
    bus.enable_i = 1'b0;
    foreach (scan_exp[i]) if (i < 3) begin
      int hi;
      int bad;
      logic [3:0] d;
      d = (i == 0) ? 4'd0 : (i == 1) ? 4'd4 : 4'd15;
      bus.duty_i = d;
      @(negedge clk);
      @(negedge clk);
      hi  = 0;
      bad = 0;
      repeat (16) begin
        @(negedge clk);
        if (bus.leds_o == 8'hAA) hi++;
        else if (bus.leds_o != 8'h00) bad++;
      end
      chk("pwm_high_cycles", 32'(hi), 32'(d));
      chk("pwm_bad_values", 32'(bad), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
